// File: rtl/sr_pkg.sv
`timescale 1ns/1ps
// sr_pkg: shared types and constants for the SR flip-flop target driver.
//  state_t   : driver FSM states
//  cmd_t     : latched command kind (set, reset, hold)
//  SR_*      : {s, r} drive patterns; no pattern ever has both bits set
//  cmd_drive : maps a command to its {s, r} drive pattern
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_SET  = 2'd0,
        CMD_RST  = 2'd1,
        CMD_HOLD = 2'd2
    } cmd_t;

    localparam logic [1:0] SR_OFF = 2'b00;
    localparam logic [1:0] SR_SET = 2'b10;
    localparam logic [1:0] SR_RST = 2'b01;

    function automatic logic [1:0] cmd_drive(input cmd_t cmd);
        case (cmd)
            CMD_SET: return SR_SET;
            CMD_RST: return SR_RST;
            default: return SR_OFF;
        endcase
    endfunction

endpackage

// File: rtl/sr_timeout_counter.sv
`timescale 1ns/1ps
// sr_timeout_counter: loadable down counter with terminal-count flag.
//  clk   in  rising-edge clock
//  reset in  asynchronous active-high reset
//  load  in  reload with N-1 (has priority over en)
//  en    in  decrement by one, stopping at zero
//  tc    out high while the count is zero, i.e. during the N-th enabled cycle
//            after a load
module sr_timeout_counter #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= W'(N - 1);
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign tc = (cnt_reg == '0);

endmodule

// File: rtl/sr_target_driver.sv
`timescale 1ns/1ps
// sr_target_driver: drives an SR flip-flop to a requested level.
// A command (tgt_q / tgt_hold) is accepted over a valid/ready handshake in
// IDLE, turned into an s or r pulse of HOLD_CYCLES cycles (none for hold),
// then q_in is compared with the predicted level for up to TIMEOUT cycles.
// Ports:
//  clk, reset            clock, asynchronous active-high reset
//  tgt_valid/tgt_ready   command handshake (ready only in IDLE)
//  tgt_q, tgt_hold       requested level, hold (no drive) command
//  s, r                  registered flip-flop drives, never both high
//  q_in                  flip-flop output, synchronous to clk
//  q_exp                 predicted flip-flop level
//  busy                  command in progress
//  done, err             one-cycle completion / failure pulses
//  clear_err, err_cnt    synchronous clear, saturating error count
module sr_target_driver
    import sr_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int TIMEOUT     = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic             tgt_q,
    input  logic             tgt_hold,
    output logic             s,
    output logic             r,
    input  logic             q_in,
    output logic             q_exp,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             clear_err,
    output logic [ERR_W-1:0] err_cnt
);

    state_t             state_reg, state_next;
    cmd_t               cmd_reg, cmd_next;
    logic               q_exp_reg, q_exp_next;
    logic [1:0]         sr_reg, sr_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic [ERR_W-1:0]   err_cnt_reg, err_cnt_next;

    logic hold_load, hold_en, hold_tc;
    logic to_load, to_en, to_tc;

    sr_timeout_counter #(.N(HOLD_CYCLES)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (hold_load),
        .en    (hold_en),
        .tc    (hold_tc)
    );

    sr_timeout_counter #(.N(TIMEOUT)) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (to_load),
        .en    (to_en),
        .tc    (to_tc)
    );

    // Ready is masked by reset so nothing can be accepted while held in reset.
    assign tgt_ready = (state_reg == IDLE) && !reset;

    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        q_exp_next = q_exp_reg;
        sr_next    = SR_OFF;
        done_next  = 1'b0;
        err_next   = 1'b0;
        hold_load  = 1'b0;
        hold_en    = 1'b0;
        to_load    = 1'b0;
        to_en      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (tgt_valid && tgt_ready) begin
                    cmd_next = tgt_hold ? CMD_HOLD : (tgt_q ? CMD_SET : CMD_RST);
                    if (!tgt_hold) begin
                        q_exp_next = tgt_q;
                    end
                    // Drive registers start with the state change so the
                    // pulse is exactly HOLD_CYCLES cycles wide.
                    sr_next    = cmd_drive(cmd_next);
                    hold_load  = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                hold_en = 1'b1;
                if (hold_tc) begin
                    to_load    = 1'b1;
                    state_next = WAIT;
                end else begin
                    sr_next = cmd_drive(cmd_reg);
                end
            end
            WAIT: begin
                to_en = 1'b1;
                if (q_in == q_exp_reg) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (to_tc) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Clear takes priority over a coincident increment.
        err_cnt_next = err_cnt_reg;
        if (clear_err) begin
            err_cnt_next = '0;
        end else if (err_next && (err_cnt_reg != {ERR_W{1'b1}})) begin
            err_cnt_next = err_cnt_reg + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cmd_reg     <= CMD_HOLD;
            q_exp_reg   <= 1'b0;
            sr_reg      <= SR_OFF;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cmd_reg     <= cmd_next;
            q_exp_reg   <= q_exp_next;
            sr_reg      <= sr_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign s       = sr_reg[1];
    assign r       = sr_reg[0];
    assign q_exp   = q_exp_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign err     = err_reg;
    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_sr_target_driver.sv
`timescale 1ns/1ps
// Testbench for sr_target_driver: main instance (HOLD_CYCLES=1) paired with a
// behavioural SR flip-flop, plus a HOLD_CYCLES=3 instance for reset-mid-drive.
module tb_sr_target_driver;

    localparam int H  = 1;
    localparam int TO = 4;
    localparam int EW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic reset = 1'b1;
    logic tgt_valid = 1'b0, tgt_q = 1'b0, tgt_hold = 1'b0, clear_err = 1'b0;
    logic tgt_ready, s, r, q_in, q_exp, busy, done, err;
    logic [EW-1:0] err_cnt;

    // flip-flop driven by the main instance, optionally overridden
    logic ff_q = 1'b0, force_en = 1'b0, force_val = 1'b0;
    assign q_in = force_en ? force_val : ff_q;
    always @(posedge clk) begin
        if (s)      ff_q <= 1'b1;
        else if (r) ff_q <= 1'b0;
    end

    sr_target_driver #(.HOLD_CYCLES(H), .TIMEOUT(TO), .ERR_W(EW)) dut (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_q(tgt_q), .tgt_hold(tgt_hold), .s(s), .r(r), .q_in(q_in),
        .q_exp(q_exp), .busy(busy), .done(done), .err(err),
        .clear_err(clear_err), .err_cnt(err_cnt)
    );

    // HOLD_CYCLES=3 instance
    logic reset3 = 1'b1;
    logic v3 = 1'b0, tq3 = 1'b0, th3 = 1'b0, clr3 = 1'b0, qin3 = 1'b0;
    logic rdy3, s3, r3, qexp3, busy3, done3, err3;
    logic [EW-1:0] cnt3;

    sr_target_driver #(.HOLD_CYCLES(3), .TIMEOUT(TO), .ERR_W(EW)) dut3 (
        .clk(clk), .reset(reset3), .tgt_valid(v3), .tgt_ready(rdy3),
        .tgt_q(tq3), .tgt_hold(th3), .s(s3), .r(r3), .q_in(qin3),
        .q_exp(qexp3), .busy(busy3), .done(done3), .err(err3),
        .clear_err(clr3), .err_cnt(cnt3)
    );

    int errors = 0;
    int checks = 0;
    int bad_sr = 0;
    int bad_de = 0;
    int txn = 0;

    // reference model state
    logic m_ff = 1'b0, m_qexp = 1'b0;
    int   m_cnt = 0;

    always @(negedge clk) begin
        if ((s && r) || (s3 && r3))        bad_sr++;
        if ((done && err) || (done3 && err3)) bad_de++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One command on the main instance; expectations come from the model.
    task automatic run_cmd(input logic q, input logic hold, input logic fe,
                           input logic fv, input logic clr);
        logic exp_qexp, ff_after, qv, match;
        int exp_k, exp_kind, exp_s, exp_r, exp_cnt;
        int got_k, got_kind, s_n, r_n;
        exp_qexp = hold ? m_qexp : q;
        ff_after = hold ? m_ff : q;
        qv       = fe ? fv : ff_after;
        match    = (qv == exp_qexp);
        exp_kind = match ? 1 : 2;
        exp_k    = match ? H + 2 : H + 1 + TO;
        exp_s    = (!hold && q)  ? H : 0;
        exp_r    = (!hold && !q) ? H : 0;
        if (match)    exp_cnt = m_cnt;
        else if (clr) exp_cnt = 0;
        else          exp_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;

        @(negedge clk);
        chk("ready", tgt_ready, 1);
        force_en = fe; force_val = fv; tgt_q = q; tgt_hold = hold; tgt_valid = 1'b1;
        @(posedge clk);
        #1 tgt_valid = 1'b0;
        s_n = 0; r_n = 0; got_k = 0; got_kind = 0;
        for (int k = 1; k <= 40 && got_kind == 0; k++) begin
            @(negedge clk);
            clear_err = clr && !match && (k == exp_k - 1);
            s_n += int'(s);
            r_n += int'(r);
            if (done || err) begin
                got_k = k;
                got_kind = done ? 1 : 2;
            end
        end
        clear_err = 1'b0;
        chk("resp_kind", got_kind, exp_kind);
        chk("resp_latency", got_k, exp_k);
        chk("s_cycles", s_n, exp_s);
        chk("r_cycles", r_n, exp_r);
        chk("q_exp", q_exp, exp_qexp);
        chk("err_cnt", err_cnt, exp_cnt);
        chk("busy_after", busy, 0);
        @(negedge clk);
        chk("single_pulse", done | err, 0);
        m_ff = ff_after; m_qexp = exp_qexp; m_cnt = exp_cnt;
        txn++;
        $display("txn %0d q=%0d hold=%0d force=%0d/%0d clr=%0d -> kind=%0d lat=%0d err_cnt=%0d",
                 txn, q, hold, fe, fv, clr, got_kind, got_k, err_cnt);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("clear_err", err_cnt, 0);
        m_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfers, dones;
        logic prev_busy, nq;

        // reset state
        #40;
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        #60;
        reset = 1'b0;
        reset3 = 1'b0;
        @(negedge clk);
        chk("rst_q_exp", q_exp, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ready", tgt_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", done | err, 0);

        // set then reset following the flip-flop
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // q stuck at 0: timeouts, then saturation
        for (int i = 0; i < 300; i++) run_cmd(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        do_clear();

        // hold commands
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // clear coincident with a timeout error
        run_cmd(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        // redundant command
        run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // valid held through busy: exactly one transfer
        nq = ~m_ff;
        @(negedge clk);
        force_en = 1'b0; tgt_q = nq; tgt_hold = 1'b0; tgt_valid = 1'b1;
        xfers = 0; dones = 0; prev_busy = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (busy && !prev_busy) xfers++;
            if (done) dones++;
            prev_busy = busy;
            if (k == 3) tgt_valid = 1'b0;
        end
        chk("held_valid_xfers", xfers, 1);
        chk("held_valid_dones", dones, 1);
        chk("held_valid_q_exp", q_exp, nq);
        m_ff = nq; m_qexp = nq;
        $display("txn held-valid q=%0d xfers=%0d dones=%0d", nq, xfers, dones);

        // randomized commands
        for (int i = 0; i < 40; i++) begin
            logic rq, rh, rfe, rfv, rclr;
            rq   = 1'($urandom_range(0, 1));
            rh   = ($urandom_range(0, 3) == 0);
            rfe  = ($urandom_range(0, 2) == 0);
            rfv  = 1'($urandom_range(0, 1));
            rclr = rfe && ($urandom_range(0, 1) == 1);
            run_cmd(rq, rh, rfe, rfv, rclr);
        end

        // reset mid-DRIVE on the HOLD_CYCLES=3 instance
        @(negedge clk);
        tq3 = 1'b1; th3 = 1'b0; v3 = 1'b1;
        @(posedge clk);
        #1 v3 = 1'b0;
        @(negedge clk);
        chk("d3_s_drive1", s3, 1);
        @(negedge clk);
        chk("d3_s_drive2", s3, 1);
        reset3 = 1'b1;
        #1;
        chk("d3_s_async_drop", s3, 0);
        chk("d3_r_async", r3, 0);
        chk("d3_busy_rst", busy3, 0);
        @(negedge clk);
        reset3 = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done3 || err3) dones++;
        end
        chk("d3_no_resp", dones, 0);
        chk("d3_ready", rdy3, 1);
        chk("d3_q_exp", qexp3, 0);
        chk("d3_err_cnt", cnt3, 0);
        $display("txn reset-mid-drive dut3 responses=%0d", dones);

        chk("never_s_and_r", bad_sr, 0);
        chk("never_done_and_err", bad_de, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
